// File: rtl/uart_tx_scheduler.sv
// Moves words from the TX FIFO into the UART transmitter, one frame at a time.
// Optional CTS flow control is compiled in with `define UART_TX_CTS_FLOW_CONTROL_EN.
module uart_tx_scheduler #(
  parameter int DATA_WIDTH  = 8,
  parameter bit FWFT        = 1'b1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   enable_i,
  input  logic                   fifo_empty_i,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data_i,
  output logic                   fifo_read_o,
  input  logic                   tx_ready_i,
  input  logic                   tx_done_i,
  input  logic                   cts_n_i,
  output logic                   tx_start_o,
  output logic [DATA_WIDTH-1:0]  tx_data_o,
  output logic                   busy_o,
  output logic [COUNT_WIDTH-1:0] tx_count_o,
  output logic [1:0]             dbg_state_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LATCH = 2'd1;
  localparam logic [1:0] ST_START = 2'd2;
  localparam logic [1:0] ST_BUSY  = 2'd3;

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [DATA_WIDTH-1:0]  r_data;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   w_cts_ok;
  logic                   w_go;
  logic                   w_pop;
  logic                   w_load;
  logic                   w_frame_done;

`ifdef UART_TX_CTS_FLOW_CONTROL_EN
  logic r_cts_meta;
  logic r_cts_sync;

  // Both flops reset to "deasserted" so no pop can slip out right after reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cts_meta <= 1'b1;
      r_cts_sync <= 1'b1;
    end else begin
      r_cts_meta <= cts_n_i;
      r_cts_sync <= r_cts_meta;
    end
  end

  assign w_cts_ok = ~r_cts_sync;
`else
  logic w_unused_cts;

  assign w_unused_cts = cts_n_i;
  assign w_cts_ok     = 1'b1;
`endif

  // Handshakes: a FIFO pop is fifo_read_o for one cycle while the FIFO is
  // non-empty; the transmitter takes a frame on tx_start_o only after
  // reporting tx_ready_i, and closes it with a one-cycle tx_done_i.
  assign w_go  = enable_i & ~fifo_empty_i & tx_ready_i & w_cts_ok;
  assign w_pop = (r_state == ST_IDLE) & w_go;

  // FWFT data is valid alongside the pop; a standard FIFO needs an extra cycle.
  assign w_load       = FWFT ? w_pop : (r_state == ST_LATCH);
  assign w_frame_done = (r_state == ST_BUSY) & tx_done_i;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_state_nxt = FWFT ? ST_START : ST_LATCH;
        end
      end
      ST_LATCH: w_state_nxt = ST_START;
      ST_START: w_state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (tx_done_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_data <= '0;
    end else if (w_load) begin
      r_data <= fifo_rd_data_i;
    end
  end

  // Wraps silently at the top of its range.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_count <= '0;
    end else if (w_frame_done) begin
      r_count <= r_count + COUNT_WIDTH'(1);
    end
  end

  // The pop strobe is gated by reset so it reads 0 while rst_n_i is low.
  assign fifo_read_o = w_pop & rst_n_i;
  assign tx_start_o  = (r_state == ST_START);
  assign busy_o      = (r_state != ST_IDLE);
  assign tx_data_o   = r_data;
  assign tx_count_o  = r_count;
  assign dbg_state_o = r_state;

endmodule
